// File: rtl/graph_mem_arb_pkg.sv
// Shared types and constants for the graph memory read-port arbiter.
package graph_mem_arb_pkg;

  localparam int NUM_REQ_MAX = 8;
  localparam int REQ_ID_W    = $clog2(NUM_REQ_MAX);
  localparam int GRANT_CNT_W = 16;

  typedef struct packed {
    logic                valid;
    logic [REQ_ID_W-1:0] id;
  } mem_tag_t;

endpackage

// File: rtl/graph_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or above ptr_i, with wrap.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = PTR_W'((int'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/graph_mem_arbiter.sv
// Round-robin sharing of one graph-memory read port, with a fixed-latency tag pipeline for response routing.
// Optional per-requester grant counters are enabled by defining GRAPH_MEM_ARB_PERF_EN.
module graph_mem_arbiter
  import graph_mem_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [NUM_REQ-1:0]     req_valid_in,
  input  logic [ADDR_W-1:0]      req_addr_in [NUM_REQ],
  output logic [NUM_REQ-1:0]     req_ready_out,
  output logic [NUM_REQ-1:0]     rsp_valid_out,
  output logic [DATA_W-1:0]      rsp_data_out,
  output logic                   mem_valid_out,
  output logic [ADDR_W-1:0]      mem_req_out,
  input  logic                   mem_valid_in,
  input  logic [DATA_W-1:0]      mem_data_in,
  output logic                   tag_error_out,
  output logic [GRANT_CNT_W-1:0] grant_count_out [NUM_REQ]
);

  localparam int PTR_W   = $clog2(NUM_REQ);
  localparam int BLANK_W = $clog2(MEM_LATENCY + 1);

  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  grant;
  logic                gnt_any;
  logic [REQ_ID_W-1:0] gnt_id;
  logic [ADDR_W-1:0]   gnt_addr;

  logic                mem_valid_q;
  logic [ADDR_W-1:0]   mem_req_q, mem_req_d;
  mem_tag_t            issue_tag_q, issue_tag_d;
  mem_tag_t            tag_q [MEM_LATENCY];
  mem_tag_t            tag_fin;

  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                err_q, err_d;
  logic [BLANK_W-1:0]  blank_q, blank_d;
  logic                mem_ok, stray, lost;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req_i   (req_valid_in),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  // Grant stage: combinational pick, gated off while reset is asserted
  assign req_ready_out = rst_in ? grant : '0;
  assign gnt_any       = |req_ready_out;

  always_comb begin
    gnt_id   = '0;
    gnt_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready_out[i]) begin
        gnt_id   = REQ_ID_W'(i);
        gnt_addr = req_addr_in[i];
      end
    end
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = PTR_W'((int'(gnt_id) + 1) % NUM_REQ);
    end
    mem_req_d         = gnt_any ? gnt_addr : mem_req_q;
    issue_tag_d.valid = gnt_any;
    issue_tag_d.id    = gnt_id;
  end

  // Response stage: match the oldest tag against the memory strobe
  assign tag_fin = tag_q[MEM_LATENCY-1];
  assign mem_ok  = mem_valid_in & tag_fin.valid;
  // Stale responses to reads dropped by a reset land inside the blanking window
  assign stray   = mem_valid_in & ~tag_fin.valid & (blank_q == '0);
  assign lost    = tag_fin.valid & ~mem_valid_in;

  always_comb begin
    rsp_valid_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mem_ok && tag_fin.id == REQ_ID_W'(i)) begin
        rsp_valid_d[i] = 1'b1;
      end
    end
    rsp_data_d = mem_ok ? mem_data_in : rsp_data_q;
    err_d      = err_q | stray | lost;
    blank_d    = (blank_q != '0) ? blank_q - 1'b1 : blank_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      ptr_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_req_q   <= '0;
      issue_tag_q <= '0;
      for (int k = 0; k < MEM_LATENCY; k++) begin
        tag_q[k] <= '0;
      end
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
      blank_q     <= BLANK_W'(MEM_LATENCY);
    end else begin
      ptr_q       <= ptr_d;
      mem_valid_q <= gnt_any;
      mem_req_q   <= mem_req_d;
      issue_tag_q <= issue_tag_d;
      tag_q[0]    <= issue_tag_q;
      for (int k = 1; k < MEM_LATENCY; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
      blank_q     <= blank_d;
    end
  end

  assign mem_valid_out = mem_valid_q;
  assign mem_req_out   = mem_req_q;
  assign rsp_valid_out = rsp_valid_q;
  assign rsp_data_out  = rsp_data_q;
  assign tag_error_out = err_q;

`ifdef GRAPH_MEM_ARB_PERF_EN
  logic [GRANT_CNT_W-1:0] cnt_q [NUM_REQ];
  logic [GRANT_CNT_W-1:0] cnt_d [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (req_valid_in[i] && req_ready_out[i] && cnt_q[i] != '1) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rst_in) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign grant_count_out = cnt_q;
`else
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_count_out[i] = '0;
    end
  end
`endif

endmodule
